// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types, counter encoding and counter update for the branch predictor
package bp_pkg;

  // 2-bit direction counter encoding
  localparam logic [1:0] BP_SNT = 2'b00;
  localparam logic [1:0] BP_WNT = 2'b01;
  localparam logic [1:0] BP_WT  = 2'b10;
  localparam logic [1:0] BP_ST  = 2'b11;

  // Widest possible tag (smallest table, 4 entries); narrower tags are zero-extended
  localparam int BP_TAG_MAX_W = 28;

  typedef struct packed {
    logic                    valid;
    logic [BP_TAG_MAX_W-1:0] tag;
    logic [31:0]             target;
    logic [1:0]              ctr;
  } bp_entry_t;

  // Saturating step of a direction counter towards the resolved outcome
  function automatic logic [1:0] bp_ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && (ctr != BP_ST)) begin
      nxt = ctr + 2'd1;
    end else if (!taken && (ctr != BP_SNT)) begin
      nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bp_btb_array.sv
// rtl/bp_btb_array.sv - BTB storage with two async read ports and one sync write port
module bp_btb_array
  import bp_pkg::*;
#(
  parameter  int ENTRIES = 64,
  localparam int IDX_W   = $clog2(ENTRIES),
  localparam int TAG_W   = 30 - IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output bp_entry_t        rd_entry,
  input  logic [IDX_W-1:0] up_idx,
  output bp_entry_t        up_entry,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  bp_entry_t        wr_entry
);

  // Tag and target are never read while the matching valid bit is clear, so they need no reset
  logic [TAG_W-1:0]   tag_mem    [ENTRIES];
  logic [31:0]        target_mem [ENTRIES];
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [1:0]         ctr_q [ENTRIES];
  logic [1:0]         ctr_d [ENTRIES];
  logic               unused_tag_bits;

  assign unused_tag_bits = ^wr_entry.tag;

  // Next state of the resettable valid bits and direction counters
  always_comb begin
    valid_d = valid_q;
    ctr_d   = ctr_q;
    if (wr_en) begin
      valid_d[wr_idx] = wr_entry.valid;
      ctr_d[wr_idx]   = wr_entry.ctr;
    end
  end

  // Valid bits clear and counters return to weak not-taken on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= BP_WNT;
      end
    end else begin
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
    end
  end

  // Tag and target storage, written on the single write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]    <= wr_entry.tag[TAG_W-1:0];
      target_mem[wr_idx] <= wr_entry.target;
    end
  end

  // Asynchronous reads: fetch port and training port
  always_comb begin
    rd_entry.valid  = valid_q[rd_idx];
    rd_entry.tag    = BP_TAG_MAX_W'(tag_mem[rd_idx]);
    rd_entry.target = target_mem[rd_idx];
    rd_entry.ctr    = ctr_q[rd_idx];
    up_entry.valid  = valid_q[up_idx];
    up_entry.tag    = BP_TAG_MAX_W'(tag_mem[up_idx]);
    up_entry.target = target_mem[up_idx];
    up_entry.ctr    = ctr_q[up_idx];
  end

endmodule

// File: rtl/branch_target_predictor.sv
// rtl/branch_target_predictor.sv - BTB + 2-bit direction predictor with misprediction detect and stats (optional gshare: BP_GSHARE_EN)
module branch_target_predictor
  import bp_pkg::*;
#(
  parameter  int ENTRIES = 64,
  parameter  int GHR_W   = 6,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pc_if,
  output logic             pred_taken,
  output logic [31:0]      pred_npc,
  output logic [IDX_W-1:0] pred_idx,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_is_br,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target,
  input  logic             upd_pred_taken,
  input  logic [31:0]      upd_pred_npc,
  output logic             mispredict,
  output logic [31:0]      redirect_pc,
  output logic [31:0]      stat_branches,
  output logic [31:0]      stat_mispredicts
);

  localparam int TAG_W = 30 - IDX_W;

  logic [IDX_W-1:0] fetch_idx;
  logic [TAG_W-1:0] fetch_tag;
  logic [TAG_W-1:0] upd_tag;
  logic             fetch_hit;
  logic             upd_hit;
  logic [31:0]      actual_npc;
  logic             wr_en;
  bp_entry_t        fetch_entry;
  bp_entry_t        upd_entry;
  bp_entry_t        wr_entry;
  logic [31:0]      stat_branches_q, stat_branches_d;
  logic [31:0]      stat_mispredicts_q, stat_mispredicts_d;
  logic             unused_ok;

  // The predicted-direction bit travels with the instruction but only the predicted NPC decides a flush
  assign unused_ok = &{1'b0, pc_if[1:0], upd_pc[1:0], upd_pred_taken, 1'(GHR_W)};

  bp_btb_array #(
    .ENTRIES (ENTRIES)
  ) u_btb (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (fetch_idx),
    .rd_entry (fetch_entry),
    .up_idx   (upd_idx),
    .up_entry (upd_entry),
    .wr_en    (wr_en),
    .wr_idx   (upd_idx),
    .wr_entry (wr_entry)
  );

`ifdef BP_GSHARE_EN
  logic [GHR_W-1:0] ghr_q, ghr_d;

  // Global history records resolved conditional branches only
  always_comb begin
    ghr_d = ghr_q;
    if (upd_valid && upd_is_br) begin
      ghr_d = GHR_W'({ghr_q, upd_taken});
    end
  end

  // Global history register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end
`endif

  // Fetch-side lookup and next-PC prediction
  always_comb begin
    fetch_tag = pc_if[31:IDX_W+2];
`ifdef BP_GSHARE_EN
    fetch_idx = pc_if[IDX_W+1:2] ^ IDX_W'(ghr_q);
`else
    fetch_idx = pc_if[IDX_W+1:2];
`endif
    fetch_hit  = fetch_entry.valid && (fetch_entry.tag == BP_TAG_MAX_W'(fetch_tag));
    pred_taken = fetch_hit && fetch_entry.ctr[1];
    pred_npc   = pred_taken ? fetch_entry.target : (pc_if + 32'd4);
    pred_idx   = fetch_idx;
  end

  // Training policy: counter step on hit, allocate on taken miss, leave not-taken misses alone
  always_comb begin
    upd_tag         = upd_pc[31:IDX_W+2];
    upd_hit         = upd_entry.valid && (upd_entry.tag == BP_TAG_MAX_W'(upd_tag));
    wr_en           = upd_valid && (upd_hit || upd_taken);
    wr_entry.valid  = 1'b1;
    wr_entry.tag    = BP_TAG_MAX_W'(upd_tag);
    wr_entry.target = upd_taken ? upd_target : upd_entry.target;
    if (upd_hit) begin
      wr_entry.ctr = upd_is_br ? bp_ctr_next(upd_entry.ctr, upd_taken) : BP_ST;
    end else begin
      wr_entry.ctr = upd_is_br ? BP_WT : BP_ST;
    end
  end

  // Misprediction compare against the resolved next PC
  always_comb begin
    actual_npc  = upd_taken ? upd_target : (upd_pc + 32'd4);
    mispredict  = upd_valid && (upd_pred_npc != actual_npc);
    redirect_pc = actual_npc;
  end

  // Saturating performance counters
  always_comb begin
    stat_branches_d    = stat_branches_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (upd_valid && (stat_branches_q != 32'hFFFF_FFFF)) begin
      stat_branches_d = stat_branches_q + 32'd1;
    end
    if (mispredict && (stat_mispredicts_q != 32'hFFFF_FFFF)) begin
      stat_mispredicts_d = stat_mispredicts_q + 32'd1;
    end
  end

  // Performance counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;

endmodule
